// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between the fetch (IF) and memory (DM) stages
module unified_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LATENCY    = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rdy,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_rdy,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t        state, state_n;
   logic [3:0]    cnt;
   logic [SW-1:0] starve;
   logic          grant;
   logic          arb, dm_win;
   // arbitration decision and next state; DM wins unless IF has waited out STARVE_MAX DM grants
   always_comb begin
      arb     = (state == IDLE) && (if_req || dm_req);
      dm_win  = dm_req && !(if_req && starve == SW'(STARVE_MAX));
      state_n = (state == IDLE)   ? (arb ? ACCESS : IDLE) :
                (state == ACCESS) ? ((cnt == 4'd0) ? RESP : ACCESS) : IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end
   // latch the winner, count the access down and register the completion pulse and data
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         starve    <= '0;
         grant     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdy    <= 1'b0;
         dm_rdy    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_rdy <= 1'b0;
         dm_rdy <= 1'b0;
         if (arb) begin
            grant     <= dm_win;
            cnt       <= 4'(LATENCY - 1);
            starve    <= (dm_win && if_req) ? ((starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1)) : '0;
            mem_en    <= 1'b1;
            mem_we    <= dm_win & dm_we;
            mem_addr  <= dm_win ? dm_addr : if_addr;
            mem_wdata <= dm_win ? dm_wdata : '0;
         end else if (state == ACCESS) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd0) begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (grant) begin
                  dm_rdy   <= 1'b1;
                  dm_rdata <= mem_we ? '0 : mem_rdata;
               end else begin
                  if_rdy   <= 1'b1;
                  if_rdata <= mem_rdata;
               end
            end
         end
      end
   end
   assign stall_if  = rst & if_req & ~if_rdy;
   assign stall_mem = rst & dm_req & ~dm_rdy;
endmodule
